block_ram_read_port: RTL and testbench

BLOCK_RAM_READ_PORT -- requirements
Module: block_ram_read_port

---
 rtl/block_ram_read_port.sv | 90 +++++++++
 tb/tb_block_ram_read_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_read_port.sv
// Request/response front end for a single-port synchronous RAM.
// Writes go straight to the RAM. Reads return RAM_DO one cycle later,
// either bypassed directly to the consumer or parked in a 2-entry skid
// FIFO while the consumer stalls. REQ_READY only rises when there is
// guaranteed room for the response, so nothing is ever dropped.
module block_ram_read_port #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  RAM_WE,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    // Read issued last cycle; RAM_DO holds its data this cycle.
    logic                  inflight;
    // Response FIFO bookkeeping.
    logic [1:0]            occ;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [2];

    logic                  req_fire;
    logic                  read_fire;
    logic                  deq;
    logic                  bypass;
    logic                  fifo_enq;
    logic                  fifo_deq;
    logic [2:0]            pending;
    logic [1:0]            occ_next;

    // Handshake, bypass and FIFO control decisions for the current cycle.
    always_comb begin
        RAM_ADDR   = REQ_ADDR;
        RAM_DI     = REQ_DATA;
        RESP_VALID = RESET_N && ((occ != 2'd0) || inflight);
        bypass     = (occ == 2'd0) && inflight;
        RESP_DATA  = bypass ? RAM_DO : fifo_mem[rd_ptr];
        deq        = RESP_VALID && RESP_READY;
        // Responses still owed after this cycle's dequeue; a new read may
        // only be issued if its response is sure to find a free slot.
        pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
        REQ_READY  = RESET_N && (pending < 3'd2);
        req_fire   = REQ_VALID && REQ_READY;
        read_fire  = req_fire && !REQ_WE;
        RAM_WE     = req_fire && REQ_WE;
        // A bypassed response taken this cycle never needs buffering.
        fifo_enq   = inflight && !(bypass && deq);
        fifo_deq   = deq && (occ != 2'd0);
        occ_next   = occ + {1'b0, fifo_enq} - {1'b0, fifo_deq};
    end

    // Control state; reset discards any buffered or in-flight responses.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= read_fire;
            occ      <= occ_next;
            if (fifo_enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_deq) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // FIFO payload storage; contents are qualified by occ so no reset.
    always_ff @(posedge CLK) begin
        if (fifo_enq) begin
            fifo_mem[wr_ptr] <= RAM_DO;
        end
    end

endmodule

// File: tb/tb_block_ram_read_port.sv
// Directed and randomised checks for block_ram_read_port, with a
// write-first single-port RAM model attached to the RAM_* pins.
module tb_block_ram_read_port;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          CLK;
    logic          RESET_N;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_DATA;
    logic          RESP_VALID;
    logic          RESP_READY;
    logic [DW-1:0] RESP_DATA;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_WE;
    logic [DW-1:0] RAM_DI;
    logic [DW-1:0] RAM_DO;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [DW-1:0] shadow [16];
    logic [DW-1:0] ram_mem [16];
    logic          ram_loaded = 1'b0;
    logic [DW-1:0] exp_q [$];
    int            max_occ = 0;

    block_ram_read_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WE     (REQ_WE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_DATA   (REQ_DATA),
        .RESP_VALID (RESP_VALID),
        .RESP_READY (RESP_READY),
        .RESP_DATA  (RESP_DATA),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_WE     (RAM_WE),
        .RAM_DI     (RAM_DI),
        .RAM_DO     (RAM_DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] init_val(input int i);
        logic [31:0] v;
        v = i * 29 + 17;
        if (i == 5) return 8'hA3;
        return v[DW-1:0];
    endfunction

    // RAM model: preloads on the first edge, then write-first, 1-cycle read.
    always @(posedge CLK) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
            RAM_DO <= '0;
        end else if (RAM_WE) begin
            ram_mem[RAM_ADDR] <= RAM_DI;
            RAM_DO <= RAM_DI;
        end else begin
            RAM_DO <= ram_mem[RAM_ADDR];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic rr);
        @(negedge CLK);
        REQ_VALID  = v;
        REQ_WE     = we;
        REQ_ADDR   = a;
        REQ_DATA   = d;
        RESP_READY = rr;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        RESET_N    = 1'b0;
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b1;
        REQ_ADDR   = '0;
        REQ_DATA   = 8'hFF;
        RESP_READY = 1'b1;

        // Reset holds everything quiet even with a write request present.
        repeat (3) @(negedge CLK);
        #1;
        checkOutput("rst_req_ready", REQ_READY, 0);
        checkOutput("rst_resp_valid", RESP_VALID, 0);
        checkOutput("rst_ram_we", RAM_WE, 0);
        checkOutput("rst_occ", dut.occ, 0);

        // First cycle after release accepts a request.
        @(negedge CLK);
        RESET_N   = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        #1;
        checkOutput("post_rst_ready", REQ_READY, 1);

        // Single read of address 5 returns 0xA3 with one cycle latency.
        applyStimulus(1, 0, 5, 0, 1);
        checkOutput("single_ready", REQ_READY, 1);
        checkOutput("single_ram_addr", RAM_ADDR, 5);
        checkOutput("single_no_we", RAM_WE, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single_valid", RESP_VALID, 1);
        checkOutput("single_data", RESP_DATA, 8'hA3);
        checkOutput("single_occ", dut.occ, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single_idle", RESP_VALID, 0);

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, AW'(i), 0, 1);
            checkOutput("stream_ready", REQ_READY, 1);
            if (i > 0) begin
                checkOutput("stream_valid", RESP_VALID, 1);
                checkOutput("stream_data", RESP_DATA, shadow[i-1]);
            end
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("stream_last_valid", RESP_VALID, 1);
        checkOutput("stream_last_data", RESP_DATA, shadow[7]);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("stream_idle", RESP_VALID, 0);

        // Back-pressure: two reads accepted, third stalls until drained.
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("bp_ready1", REQ_READY, 1);
        applyStimulus(1, 0, 2, 0, 0);
        checkOutput("bp_ready2", REQ_READY, 1);
        checkOutput("bp_bypass_data", RESP_DATA, shadow[1]);
        applyStimulus(1, 0, 3, 0, 0);
        checkOutput("bp_stall1", REQ_READY, 0);
        applyStimulus(1, 0, 3, 0, 0);
        checkOutput("bp_stall2", REQ_READY, 0);
        checkOutput("bp_occ_full", dut.occ, 2);
        applyStimulus(1, 0, 3, 0, 1);
        checkOutput("bp_resume_ready", REQ_READY, 1);
        checkOutput("bp_data1", RESP_DATA, shadow[1]);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bp_valid2", RESP_VALID, 1);
        checkOutput("bp_data2", RESP_DATA, shadow[2]);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bp_valid3", RESP_VALID, 1);
        checkOutput("bp_data3", RESP_DATA, shadow[3]);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bp_idle", RESP_VALID, 0);

        // Write then read the same address on the next cycle.
        applyStimulus(1, 1, 9, 8'h5A, 1);
        checkOutput("wr_ram_we", RAM_WE, 1);
        checkOutput("wr_ram_di", RAM_DI, 8'h5A);
        shadow[9] = 8'h5A;
        applyStimulus(1, 0, 9, 0, 1);
        checkOutput("wr_no_resp", RESP_VALID, 0);
        checkOutput("rd_ram_we", RAM_WE, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("wr_rd_valid", RESP_VALID, 1);
        checkOutput("wr_rd_data", RESP_DATA, 8'h5A);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("wr_rd_idle", RESP_VALID, 0);

        // Randomised traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            logic v, we, rr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 2) != 0);
            a  = AW'($urandom_range(0, 15));
            d  = DW'($urandom_range(0, 255));
            applyStimulus(v, we, a, d, rr);
            if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
            if (RESP_VALID && RESP_READY) begin
                if (exp_q.size() == 0) checkOutput("rand_spurious", 1, 0);
                else checkOutput("rand_data", RESP_DATA, exp_q.pop_front());
            end
            checkOutput("rand_ram_we", RAM_WE, v && REQ_READY && we);
            if (REQ_VALID && REQ_READY) begin
                if (we) shadow[a] = d;
                else exp_q.push_back(shadow[a]);
            end
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 0, 0, 1);
            if (RESP_VALID) begin
                if (exp_q.size() == 0) checkOutput("drain_spurious", 1, 0);
                else checkOutput("drain_data", RESP_DATA, exp_q.pop_front());
            end
        end
        checkOutput("rand_all_returned", exp_q.size(), 0);
        checkOutput("rand_occ_bound", max_occ <= 2, 1);

        // Reset mid-operation with one buffered and one in-flight response.
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid_occ", dut.occ, 1);
        checkOutput("mid_inflight", dut.inflight, 1);
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_valid", RESP_VALID, 0);
        checkOutput("mid_rst_ready", REQ_READY, 0);
        applyStimulus(0, 0, 0, 0, 1);
        RESET_N = 1'b1;
        #1;
        checkOutput("mid_rel_valid", RESP_VALID, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("mid_no_stale", RESP_VALID, 0);
        checkOutput("mid_occ_clear", dut.occ, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
